// File: rtl/shift_fifo_pkg.sv
// Shared types and helpers for the shift-register FIFO.
package shift_fifo_pkg;

  // State-update selector, packed as {push, pop}.
  typedef enum logic [1:0] {
    HOLD = 2'b00,
    POP  = 2'b01,
    PUSH = 2'b10,
    BOTH = 2'b11
  } op_e;

  // Bits needed to hold an occupancy of 0..depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/shift_fifo_slot.sv
// One storage slot of the shift FIFO: loads new data, the next slot's value, or holds.
module shift_fifo_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_in,
  input  logic             load_next,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] next_data,
  output logic [WIDTH-1:0] q
);

  // Slot register; a write of new data takes precedence over the shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load_in) begin
      q <= in_data;
    end else if (load_next) begin
      q <= next_data;
    end
  end

endmodule

// File: rtl/shift_fifo.sv
// Shift-register FIFO with valid/ready on both sides; entries compact toward slot 0.
module shift_fifo
  import shift_fifo_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = DEPTH - 1,
  parameter int FULL_PUSH   = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_full,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int CW = cnt_width(DEPTH);

  logic             push;
  logic             pop;
  logic [CW-1:0]    wr_idx;
  op_e              op;
  logic [WIDTH-1:0] regs      [DEPTH];
  logic [WIDTH-1:0] next_data [DEPTH];
  logic             load_in   [DEPTH];
  logic             load_next [DEPTH];

  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign almost_full = (count >= CW'(AFULL_LEVEL));
  assign out_valid   = !empty;
  assign in_ready    = (FULL_PUSH != 0) ? (!full || out_ready) : !full;
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign out_data    = regs[0];

  // With a simultaneous pop every entry moves down one, so the new entry lands one slot lower.
  assign wr_idx      = count - CW'(pop);

  // Classify this cycle's update.
  always_comb begin
    op = op_e'({push, pop});
  end

  // Occupancy tracking; push/pop gating keeps it within 0..DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case (op)
        PUSH:    count <= count + CW'(1);
        POP:     count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky protocol-error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (in_valid && !in_ready) overflow <= 1'b1;
      if (out_ready && !out_valid) underflow <= 1'b1;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    assign load_in[i] = push && (wr_idx == CW'(i));
    if (i < DEPTH - 1) begin : g_shift
      assign load_next[i] = pop;
      assign next_data[i] = regs[i+1];
    end else begin : g_tail
      assign load_next[i] = 1'b0;
      assign next_data[i] = '0;
    end

    shift_fifo_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_in   (load_in[i]),
      .load_next (load_next[i]),
      .in_data   (in_data),
      .next_data (next_data[i]),
      .q         (regs[i])
    );
  end

endmodule

// File: tb/tb_shift_fifo.sv
// Bench for shift_fifo: two instances (FULL_PUSH=0 and 1) share stimulus; queue models predict both.
module tb_shift_fifo;

  localparam int W = 16;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_ready;

  logic         in_rdy [2];
  logic         o_vld  [2];
  logic [W-1:0] o_data [2];
  logic [2:0]   cnt    [2];
  logic         emp    [2];
  logic         ful    [2];
  logic         afull  [2];
  logic         ovf    [2];
  logic         udf    [2];

  logic [W-1:0] mq   [2][$];
  bit           movf [2];
  bit           mudf [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_fifo #(.WIDTH(W), .DEPTH(D), .AFULL_LEVEL(D-1), .FULL_PUSH(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[0]), .in_data(in_data),
    .out_valid(o_vld[0]), .out_ready(out_ready), .out_data(o_data[0]), .count(cnt[0]),
    .empty(emp[0]), .full(ful[0]), .almost_full(afull[0]), .overflow(ovf[0]), .underflow(udf[0])
  );

  shift_fifo #(.WIDTH(W), .DEPTH(D), .AFULL_LEVEL(D-1), .FULL_PUSH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[1]), .in_data(in_data),
    .out_valid(o_vld[1]), .out_ready(out_ready), .out_data(o_data[1]), .count(cnt[1]),
    .empty(emp[1]), .full(ful[1]), .almost_full(afull[1]), .overflow(ovf[1]), .underflow(udf[1])
  );

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      movf[k] = 0;
      mudf[k] = 0;
    end
  endtask

  // Inputs are driven 1 time unit after a rising edge.
  task automatic apply(input bit iv, input logic [W-1:0] d, input bit ordy);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
  endtask

  // Advance the models by the FIFO rules, take the edge, then idle the inputs.
  task automatic clock_model();
    for (int k = 0; k < 2; k++) begin
      bit rdy;
      rdy = (mq[k].size() < D) || (k == 1 && out_ready);
      if (in_valid && !rdy) movf[k] = 1;
      if (out_ready && mq[k].size() == 0) mudf[k] = 1;
      if (out_ready && mq[k].size() > 0) void'(mq[k].pop_front());
      if (in_valid && rdy) mq[k].push_back(in_data);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (emp[k] !== 1'b1 || cnt[k] !== 3'd0 || o_vld[k] !== 1'b0 || o_data[k] !== 16'h0 ||
          in_rdy[k] !== 1'b1 || ovf[k] !== 1'b0 || udf[k] !== 1'b0 || afull[k] !== 1'b0 || ful[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset dut%0d: empty=%b count=%0d out_valid=%b out_data=%h in_ready=%b ovf=%b udf=%b af=%b full=%b, want 1 0 0 0000 1 0 0 0 0",
                 k, emp[k], cnt[k], o_vld[k], o_data[k], in_rdy[k], ovf[k], udf[k], afull[k], ful[k]);
      end
    end
  endtask

  task automatic test_fill_drain();
    logic [W-1:0] vals [4];
    vals = '{16'h3456, 16'h1111, 16'h2222, 16'h3333};
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, vals[i], 1'b0);
      clock_model();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (cnt[k] !== 3'(i + 1) || afull[k] !== (i + 1 >= 3) || ful[k] !== (i + 1 == 4)) begin
          errors++;
          $display("FAIL fill dut%0d step %0d: count=%0d af=%b full=%b, want %0d %b %b",
                   k, i, cnt[k], afull[k], ful[k], i + 1, (i + 1 >= 3), (i + 1 == 4));
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o_data[k] !== vals[i] || o_vld[k] !== 1'b1) begin
          errors++;
          $display("FAIL drain dut%0d step %0d: out_data=%h out_valid=%b, want %h 1", k, i, o_data[k], o_vld[k], vals[i]);
        end
      end
      apply(1'b0, '0, 1'b1);
      clock_model();
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (emp[k] !== 1'b1 || cnt[k] !== 3'd0) begin
        errors++;
        $display("FAIL drained dut%0d: empty=%b count=%0d, want 1 0", k, emp[k], cnt[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    apply(1'b1, 16'h000A, 1'b0); clock_model();
    apply(1'b1, 16'h000B, 1'b0); clock_model();
    apply(1'b1, 16'h000C, 1'b1); clock_model();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (cnt[k] !== 3'd2 || o_data[k] !== 16'h000B) begin
        errors++;
        $display("FAIL pushpop dut%0d: count=%0d out_data=%h, want 2 000b", k, cnt[k], o_data[k]);
      end
    end
    apply(1'b0, '0, 1'b1); clock_model();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_data[k] !== 16'h000C || cnt[k] !== 3'd1) begin
        errors++;
        $display("FAIL pushpop_tail dut%0d: out_data=%h count=%0d, want 000c 1", k, o_data[k], cnt[k]);
      end
    end
    apply(1'b0, '0, 1'b1); clock_model();
  endtask

  task automatic test_underflow();
    apply(1'b0, '0, 1'b1); clock_model();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (udf[k] !== 1'b1 || cnt[k] !== 3'd0) begin
        errors++;
        $display("FAIL underflow dut%0d: underflow=%b count=%0d, want 1 0", k, udf[k], cnt[k]);
      end
    end
    apply(1'b1, 16'h0055, 1'b0); clock_model();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (udf[k] !== 1'b1 || o_vld[k] !== 1'b1 || o_data[k] !== 16'h0055) begin
        errors++;
        $display("FAIL underflow_sticky dut%0d: underflow=%b out_valid=%b out_data=%h, want 1 1 0055",
                 k, udf[k], o_vld[k], o_data[k]);
      end
    end
    apply(1'b0, '0, 1'b1); clock_model();
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 16'h0100 + 16'(i), 1'b0);
      clock_model();
    end
    apply(1'b1, 16'hBEEF, 1'b1);
    checks++;
    if (in_rdy[0] !== 1'b0 || in_rdy[1] !== 1'b1) begin
      errors++;
      $display("FAIL full_in_ready: dut0=%b dut1=%b, want 0 1", in_rdy[0], in_rdy[1]);
    end
    clock_model();
    checks++;
    if (cnt[0] !== 3'd3 || ovf[0] !== 1'b1 || o_data[0] !== 16'h0101) begin
      errors++;
      $display("FAIL full_nopush dut0: count=%0d ovf=%b out_data=%h, want 3 1 0101", cnt[0], ovf[0], o_data[0]);
    end
    checks++;
    if (cnt[1] !== 3'd4 || ovf[1] !== 1'b0 || o_data[1] !== 16'h0101) begin
      errors++;
      $display("FAIL full_push dut1: count=%0d ovf=%b out_data=%h, want 4 0 0101", cnt[1], ovf[1], o_data[1]);
    end
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, '0, 1'b1);
      for (int k = 0; k < 2; k++) begin
        if (mq[k].size() > 0) begin
          checks++;
          if (o_data[k] !== mq[k][0]) begin
            errors++;
            $display("FAIL full_drain dut%0d: out_data=%h, want %h", k, o_data[k], mq[k][0]);
          end
        end
      end
      clock_model();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      apply(($urandom_range(0, 99) < 60), 16'($urandom), ($urandom_range(0, 99) < 45));
      for (int k = 0; k < 2; k++) begin
        bit exp_rdy;
        exp_rdy = (mq[k].size() < D) || (k == 1 && out_ready);
        checks++;
        if (in_rdy[k] !== exp_rdy) begin
          errors++;
          $display("FAIL rand_in_ready dut%0d cyc %0d: got %b want %b", k, n, in_rdy[k], exp_rdy);
        end
        checks++;
        if (cnt[k] !== 3'(mq[k].size()) || emp[k] !== (mq[k].size() == 0) || ful[k] !== (mq[k].size() == D) ||
            afull[k] !== (mq[k].size() >= D - 1) || o_vld[k] !== (mq[k].size() > 0) ||
            ovf[k] !== movf[k] || udf[k] !== mudf[k]) begin
          errors++;
          $display("FAIL rand_state dut%0d cyc %0d: count=%0d e=%b f=%b af=%b v=%b ovf=%b udf=%b, want count=%0d ovf=%b udf=%b",
                   k, n, cnt[k], emp[k], ful[k], afull[k], o_vld[k], ovf[k], udf[k], mq[k].size(), movf[k], mudf[k]);
        end
        if (mq[k].size() > 0) begin
          checks++;
          if (o_data[k] !== mq[k][0]) begin
            errors++;
            $display("FAIL rand_data dut%0d cyc %0d: got %h want %h", k, n, o_data[k], mq[k][0]);
          end
        end
      end
      clock_model();
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, '0, 1'b1);
      clock_model();
    end
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 16'h0A00 + 16'(i), 1'b0);
      clock_model();
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (cnt[k] !== 3'd3 || udf[k] !== 1'b1) begin
        errors++;
        $display("FAIL pre_async dut%0d: count=%0d underflow=%b, want 3 1", k, cnt[k], udf[k]);
      end
    end
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (cnt[k] !== 3'd0 || o_vld[k] !== 1'b0 || ovf[k] !== 1'b0 || udf[k] !== 1'b0 || o_data[k] !== 16'h0) begin
        errors++;
        $display("FAIL async_reset dut%0d: count=%0d out_valid=%b ovf=%b udf=%b out_data=%h, want 0 0 0 0 0000",
                 k, cnt[k], o_vld[k], ovf[k], udf[k], o_data[k]);
      end
    end
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    apply(1'b1, 16'h0077, 1'b0); clock_model();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (cnt[k] !== 3'd1 || o_data[k] !== 16'h0077) begin
        errors++;
        $display("FAIL post_async dut%0d: count=%0d out_data=%h, want 1 0077", k, cnt[k], o_data[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_underflow();
    test_full();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, want completion");
    $fatal(1);
  end

endmodule
